// File: rtl/write_line_burst_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | write_line_burst_ctrl_pkg : FSM state type, mode constants, ceil util |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package write_line_burst_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CALC      = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_REQ       = 3'd3,
        ST_RUN       = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    localparam c_MODE_ONCE = "ONCE";
    localparam c_MODE_LINE = "LINE";

    // Number of AXI words needed to hold 'bits' bits (rounded up).
    function automatic logic [31:0] ceil_beats(input logic [47:0] bits, input int unsigned axi_dsize);
        logic [47:0] q;
        logic [47:0] mask;
        q    = bits >> $clog2(axi_dsize);
        mask = 48'(axi_dsize - 1);
        return 32'(q) + {31'd0, |(bits & mask)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/write_line_burst_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | write_line_burst_ctrl_if : burst request / FIFO level handshake      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface write_line_burst_ctrl_if #(
    parameter int LSIZE = 9,
    parameter int FSIZE = 10
);
    logic [FSIZE-1:0] fifo_rd_count;
    logic             burst_req;
    logic [LSIZE-1:0] burst_len;
    logic             burst_tail;
    logic             burst_ack;
    logic             burst_done;

    modport master (
        output burst_req, burst_len, burst_tail,
        input  fifo_rd_count, burst_ack, burst_done
    );

    modport slave (
        input  burst_req, burst_len, burst_tail,
        output fifo_rd_count, burst_ack, burst_done
    );
endinterface
`default_nettype wire

// File: rtl/write_line_burst_ctrl_burst_len_calc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | burst_len_calc : 3-stage pipelined beat count (unit and frame)       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module burst_len_calc
    import write_line_burst_ctrl_pkg::*;
#(
    parameter     MODE      = "ONCE",
    parameter int AXI_DSIZE = 256,
    parameter int DSIZE     = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [15:0] vactive_i,
    input  logic [15:0] hactive_i,
    output logic [31:0] unit_beats_o,
    output logic [31:0] frame_beats_o
);

    logic [15:0] v_q;
    logic [15:0] h_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            h_q <= '0;
        end else if (load_i) begin
            v_q <= vactive_i;
            h_q <= hactive_i;
        end
    end

    generate
        if (MODE == c_MODE_LINE) begin : g_line
            logic [47:0] line_bits_d;
            logic [47:0] frame_prod_d;
            logic [31:0] unit_a_q;
            logic [15:0] v_a_q;
            logic [31:0] unit_b_q;
            logic [31:0] frame_b_q;

            assign line_bits_d  = 48'(h_q) * 48'(DSIZE);
            assign frame_prod_d = 48'(unit_a_q) * 48'(v_a_q);

            always_ff @(posedge clk) begin
                if (rst) begin
                    unit_a_q  <= '0;
                    v_a_q     <= '0;
                    unit_b_q  <= '0;
                    frame_b_q <= '0;
                end else begin
                    unit_a_q  <= ceil_beats(line_bits_d, AXI_DSIZE);
                    v_a_q     <= v_q;
                    unit_b_q  <= unit_a_q;
                    frame_b_q <= 32'(frame_prod_d);
                end
            end

            assign unit_beats_o  = unit_b_q;
            assign frame_beats_o = frame_b_q;
        end else begin : g_once
            logic [47:0] vh_a_q;
            logic [47:0] bits_b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vh_a_q   <= '0;
                    bits_b_q <= '0;
                end else begin
                    vh_a_q   <= 48'(v_q) * 48'(h_q);
                    bits_b_q <= vh_a_q * 48'(DSIZE);
                end
            end

            assign unit_beats_o  = ceil_beats(bits_b_q, AXI_DSIZE);
            assign frame_beats_o = unit_beats_o;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/write_line_burst_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | write_line_burst_ctrl : splits frames/lines into AXI write bursts    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module write_line_burst_ctrl
    import write_line_burst_ctrl_pkg::*;
#(
    parameter int NOR_BURST_LEN = 200,
    parameter     MODE          = "ONCE",
    parameter int AXI_DSIZE     = 256,
    parameter int DSIZE         = 24,
    parameter int LSIZE         = 9,
    parameter int FSIZE         = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              vactive_i,
    input  logic [15:0]              hactive_i,
    input  logic                     fsync_i,
    write_line_burst_ctrl_if.master  bus,
    output logic                     line_done_o,
    output logic                     frame_done_o,
    output logic                     busy_o,
    output logic                     overrun_o
);

    localparam logic [31:0] c_NOR_LEN = 32'(NOR_BURST_LEN);

    state_t           state_q;
    logic [1:0]       calc_cnt_q;
    logic [31:0]      unit_left_q;
    logic [31:0]      frame_left_q;
    logic             pend_q;
    logic             burst_req_q;
    logic [LSIZE-1:0] burst_len_q;
    logic             burst_tail_q;
    logic             line_done_q;
    logic             frame_done_q;
    logic             overrun_q;

    logic [31:0]      unit_beats;
    logic [31:0]      frame_beats;
    logic             tail_d;
    logic [31:0]      burst_len_d;
    logic             data_ready_d;

    // Dimensions are latched on every fsync, so a frame deferred by an
    // in-flight burst still uses the values seen with its own fsync.
    burst_len_calc #(
        .MODE      (MODE),
        .AXI_DSIZE (AXI_DSIZE),
        .DSIZE     (DSIZE)
    ) u_calc (
        .clk           (clk),
        .rst           (rst),
        .load_i        (fsync_i),
        .vactive_i     (vactive_i),
        .hactive_i     (hactive_i),
        .unit_beats_o  (unit_beats),
        .frame_beats_o (frame_beats)
    );

    assign tail_d       = (unit_left_q <= c_NOR_LEN);
    assign burst_len_d  = tail_d ? unit_left_q : c_NOR_LEN;
    assign data_ready_d = (32'(bus.fifo_rd_count) >= burst_len_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            calc_cnt_q   <= '0;
            unit_left_q  <= '0;
            frame_left_q <= '0;
            pend_q       <= 1'b0;
            burst_req_q  <= 1'b0;
            burst_len_q  <= '0;
            burst_tail_q <= 1'b0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (fsync_i) begin
                        state_q    <= ST_CALC;
                        calc_cnt_q <= '0;
                    end
                end
                ST_CALC: begin
                    if (fsync_i) begin
                        calc_cnt_q <= '0;
                    end else if (calc_cnt_q == 2'd2) begin
                        unit_left_q  <= unit_beats;
                        frame_left_q <= frame_beats;
                        if (frame_beats == 32'd0) begin
                            state_q      <= ST_DONE;
                            frame_done_q <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT_DATA;
                        end
                    end else begin
                        calc_cnt_q <= calc_cnt_q + 2'd1;
                    end
                end
                ST_WAIT_DATA: begin
                    if (fsync_i) begin
                        state_q    <= ST_CALC;
                        calc_cnt_q <= '0;
                    end else if (data_ready_d) begin
                        state_q      <= ST_REQ;
                        burst_req_q  <= 1'b1;
                        burst_len_q  <= burst_len_d[LSIZE-1:0];
                        burst_tail_q <= tail_d;
                    end
                end
                ST_REQ: begin
                    if (fsync_i) begin
                        overrun_q <= 1'b1;
                        pend_q    <= 1'b1;
                    end
                    if (bus.burst_ack) begin
                        burst_req_q  <= 1'b0;
                        unit_left_q  <= unit_left_q - 32'(burst_len_q);
                        frame_left_q <= frame_left_q - 32'(burst_len_q);
                        state_q      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (fsync_i) begin
                        overrun_q <= 1'b1;
                        pend_q    <= 1'b1;
                    end
                    if (bus.burst_done) begin
                        if (pend_q || fsync_i) begin
                            state_q    <= ST_CALC;
                            calc_cnt_q <= '0;
                            pend_q     <= 1'b0;
                        end else if (frame_left_q == 32'd0) begin
                            state_q      <= ST_DONE;
                            line_done_q  <= 1'b1;
                            frame_done_q <= 1'b1;
                        end else if (unit_left_q == 32'd0) begin
                            unit_left_q <= unit_beats;
                            line_done_q <= 1'b1;
                            state_q     <= ST_WAIT_DATA;
                        end else begin
                            state_q <= ST_WAIT_DATA;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.burst_req  = burst_req_q;
    assign bus.burst_len  = burst_len_q;
    assign bus.burst_tail = burst_tail_q;
    assign line_done_o    = line_done_q;
    assign frame_done_o   = frame_done_q;
    assign overrun_o      = overrun_q;
    assign busy_o         = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_write_line_burst_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_write_line_burst_ctrl : directed bench, ONCE and LINE instances   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_write_line_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] vact, hact;
    logic        fsync_o, fsync_l;
    logic        ack, done;
    logic [9:0]  fifo;
    logic        sel;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          fd_cnt_o = 0, fd_cnt_l = 0, ld_cnt_l = 0;

    always #5 clk = ~clk;

    write_line_burst_ctrl_if #(.LSIZE(9), .FSIZE(10)) bif_o ();
    write_line_burst_ctrl_if #(.LSIZE(9), .FSIZE(10)) bif_l ();

    assign bif_o.fifo_rd_count = fifo;
    assign bif_o.burst_ack     = ack;
    assign bif_o.burst_done    = done;
    assign bif_l.fifo_rd_count = fifo;
    assign bif_l.burst_ack     = ack;
    assign bif_l.burst_done    = done;

    logic ld_o, fd_o, bsy_o, ov_o;
    logic ld_l, fd_l, bsy_l, ov_l;

    write_line_burst_ctrl #(.MODE("ONCE")) u_once (
        .clk(clk), .rst(rst), .vactive_i(vact), .hactive_i(hact), .fsync_i(fsync_o),
        .bus(bif_o.master), .line_done_o(ld_o), .frame_done_o(fd_o),
        .busy_o(bsy_o), .overrun_o(ov_o)
    );

    write_line_burst_ctrl #(.MODE("LINE")) u_line (
        .clk(clk), .rst(rst), .vactive_i(vact), .hactive_i(hact), .fsync_i(fsync_l),
        .bus(bif_l.master), .line_done_o(ld_l), .frame_done_o(fd_l),
        .busy_o(bsy_l), .overrun_o(ov_l)
    );

    logic       req, tail, ldn, fdn, bsy, ovr;
    logic [8:0] len;
    assign req  = sel ? bif_l.burst_req  : bif_o.burst_req;
    assign len  = sel ? bif_l.burst_len  : bif_o.burst_len;
    assign tail = sel ? bif_l.burst_tail : bif_o.burst_tail;
    assign ldn  = sel ? ld_l  : ld_o;
    assign fdn  = sel ? fd_l  : fd_o;
    assign bsy  = sel ? bsy_l : bsy_o;
    assign ovr  = sel ? ov_l  : ov_o;

    always @(posedge clk) begin
        if (fd_o) fd_cnt_o++;
        if (fd_l) fd_cnt_l++;
        if (ld_l) ld_cnt_l++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic s, input logic [15:0] v, input logic [15:0] h);
        vact = v;
        hact = h;
        if (s) fsync_l = 1'b1;
        else   fsync_o = 1'b1;
        tick();
        fsync_o = 1'b0;
        fsync_l = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 100 && !req; i++) tick();
        check({tag, "_req"}, req, 1);
    endtask

    task automatic do_burst(input string tag, input logic [8:0] exp_len, input logic exp_tail,
                            input logic [9:0] fifo_after = 10'd1023);
        wait_req(tag);
        check({tag, "_len"}, len, exp_len);
        check({tag, "_tail"}, tail, exp_tail);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check({tag, "_req_drop"}, req, 0);
        tick();
        fifo = fifo_after;
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; vact = '0; hact = '0; fsync_o = 1'b0; fsync_l = 1'b0;
        ack = 1'b0; done = 1'b0; fifo = 10'd1023; sel = 1'b0;
        repeat (3) tick();
        check("rst_req", req, 0);
        check("rst_len", len, 0);
        check("rst_busy", bsy, 0);
        check("rst_fd", fdn, 0);
        check("rst_ov", ovr, 0);
        rst = 1'b0;
        tick();

        // ONCE 1000x3 -> 282 beats: 200 + 82
        start_frame(1'b0, 16'd3, 16'd1000);
        do_burst("t1_b0", 9'd200, 1'b0);
        check("t1_fd_early", fdn, 0);
        do_burst("t1_b1", 9'd82, 1'b1);
        check("t1_fd", fdn, 1);
        check("t1_ld", ldn, 1);
        tick();
        check("t1_busy", bsy, 0);
        check("t1_fd_cnt", fd_cnt_o, 1);

        // ONCE 640x480 -> 144 bursts of 200
        start_frame(1'b0, 16'd480, 16'd640);
        for (int i = 0; i < 144; i++) do_burst("t2", 9'd200, (i == 143));
        tick();
        check("t2_fd_cnt", fd_cnt_o, 2);

        // tail waits for FIFO level: 81 is one short of 82
        start_frame(1'b0, 16'd3, 16'd1000);
        do_burst("t4_b0", 9'd200, 1'b0, 10'd81);
        repeat (5) tick();
        check("t4_hold", req, 0);
        fifo = 10'd82;
        tick();
        check("t4_req", req, 1);
        check("t4_len", len, 82);
        fifo = 10'd1023;
        do_burst("t4_b1", 9'd82, 1'b1);
        tick();
        check("t4_fd_cnt", fd_cnt_o, 3);

        // fsync during RUN: overrun, drop frame, restart with latched 1000x2 -> 188 beats
        start_frame(1'b0, 16'd3, 16'd1000);
        wait_req("t5");
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        start_frame(1'b0, 16'd2, 16'd1000);
        check("t5_ov", ovr, 1);
        vact = 16'd7;
        hact = 16'd7;
        tick();
        check("t5_ov_clr", ovr, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("t5_fd_none", fdn, 0);
        check("t5_ld_none", ldn, 0);
        check("t5_busy", bsy, 1);
        do_burst("t5_new", 9'd188, 1'b1);
        check("t5_fd", fdn, 1);
        tick();
        check("t5_fd_cnt", fd_cnt_o, 4);

        // LINE 1000x4 -> 4 lines of 94 beats
        sel = 1'b1;
        start_frame(1'b1, 16'd4, 16'd1000);
        for (int i = 0; i < 4; i++) begin
            do_burst("t3", 9'd94, 1'b1);
            check("t3_ld", ldn, 1);
            check("t3_fd", fdn, (i == 3));
        end
        tick();
        check("t3_ld_cnt", ld_cnt_l, 4);
        check("t3_fd_cnt", fd_cnt_l, 1);
        sel = 1'b0;

        // vactive=0: frame_done 4 cycles after fsync, no burst
        start_frame(1'b0, 16'd0, 16'd1000);
        check("t6_busy", bsy, 1);
        tick();
        tick();
        check("t6_fd_early", fdn, 0);
        tick();
        check("t6_fd", fdn, 1);
        check("t6_noreq", req, 0);

        // synchronous reset while a request is pending
        start_frame(1'b0, 16'd3, 16'd1000);
        wait_req("t6r");
        rst = 1'b1;
        tick();
        check("t6r_req", req, 0);
        check("t6r_len", len, 0);
        check("t6r_tail", tail, 0);
        check("t6r_busy", bsy, 0);
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
